keyed_accum_fsm: RTL and testbench
==================================

# keyed_accum_fsm

Parametrised, key-locked frame accumulator FSM for the locked-FSM benchmark set. It accepts BEATS data beats over a valid/ready input, sums them, and presents the sum over a valid/ready output. The frame-start key check selects either the genuine accumulation path or a duplicated decoy path that produces a corrupted sum. Width, frame depth and key width are generic, which the fixed-width single-key benchmarks are not.

## Interface
- DATA_W, 8, input beat width (≥1)
- BEATS, 4, beats per frame (≥2)
- KEY_W, 4, key width (≥1)
- KEY_VAL, 4'hA, correct key value (KEY_W bits)
- SUM_W (localparam) = DATA_W + $clog2(BEATS); holds BEATS·(2^DATA_W−1) without overflow

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- key  in  KEY_W  unlock key; sampled on the first beat of each frame only
- in_valid  in  1  input beat valid
- in_data  in  DATA_W  input beat
- in_ready  out  1  block can accept a beat
- out_valid  out  1  frame sum valid
- out_data  out  SUM_W  frame sum
- out_ready  in  1  downstream accepts the sum
- busy  out  1  high in every state except IDLE
- frame_cnt  out  8  completed output handshakes, modulo 256

## Operation
- States: IDLE, ACC, ACC_D (decoy duplicate of ACC), OUT.
- Input handshake: a beat is taken when in_valid && in_ready. Output handshake: the sum is taken when out_valid && out_ready.
- in_ready = 1 in IDLE, ACC and ACC_D; 0 in OUT. out_valid = 1 only in OUT.
- IDLE, beat taken: beat_cnt←1. If key==KEY_VAL: acc←in_data, go to ACC. Otherwise: acc←~in_data, go to ACC_D. Both values are zero-extended to SUM_W.
- ACC, beat taken: acc←acc+in_data, beat_cnt+1. ACC_D, beat taken: acc←acc+(~in_data). Each path stays in its own state until beat BEATS is taken, then moves to OUT.
- No beat taken: state and acc hold. Bubbles are allowed anywhere in a frame.
- OUT: out_data=acc, held stable while out_ready=0. On the handshake, go to IDLE and increment frame_cnt (255→0). acc is not cleared at that point; it is overwritten by the next first beat.
- Changes on key after the first beat of a frame have no effect on that frame.
- ACC and ACC_D use separate state encodings. The decoy path produces no extra flag or port difference.

## Timing
- Reset values: state IDLE, acc 0, beat_cnt 0, frame_cnt 0, in_ready 1, out_valid 0, out_data 0, busy 0.
- Latency: out_valid rises the cycle after the handshake of beat BEATS.
- Minimum frame period is BEATS+1 cycles: beats in cycles 0..BEATS−1, output handshake in cycle BEATS, next first beat in cycle BEATS+1.
- A beat presented in OUT is not accepted in the same cycle as the output handshake (in_ready=0 there).
- Reset asserted mid-frame or in OUT: the partial frame is dropped, all registers return to their reset values immediately (asynchronously), and no output handshake occurs.
- All outputs are registered or decoded from the state register only; there is no combinational path from in_valid or out_ready to any output.

## Configuration
- LOCK_EN defined: key check and the ACC_D path are built, as described above.
- LOCK_EN undefined: ACC_D and the key comparator are removed. The key port remains but is ignored, and every frame follows ACC, giving the true sum.

## Test plan
All scenarios use DATA_W=8, BEATS=4, KEY_W=4, KEY_VAL=4'hA.
- Correct key: key=4'hA, beats 1,2,3,4 back-to-back, out_ready=1 -> out_valid in the 5th cycle with out_data=10'h00A; frame_cnt=1.
- Wrong key (LOCK_EN): key=4'h0, beats 1,2,3,4 -> out_data=254+253+252+251=10'h3F2. Without LOCK_EN the same stimulus gives 10'h00A.
- Maximum sum and backpressure: key=4'hA, four beats of 8'hFF, out_ready low for 3 cycles -> out_data=10'h3FC held stable, in_ready=0 throughout, one handshake when out_ready rises.
- Key change mid-frame plus bubbles: key=4'hA on beat 1, key=4'h3 from beat 2 on, in_valid low 2 cycles between beats -> true sum 10'h00A.
- Reset mid-frame: assert rst after beat 2 -> state IDLE, out_valid=0, frame_cnt=0. A following frame 5,5,5,5 gives 10'h014.
- Counter wrap: 256 back-to-back frames -> frame_cnt reads 0 after the last handshake and 1 after the next.

Source files
------------

// File: rtl/keyed_accum_fsm.sv
// Key-locked frame accumulator: sums BEATS input beats and presents the sum over valid/ready.
// Optional feature macro LOCK_EN builds the key check and the decoy accumulation path.
module keyed_accum_fsm #(
    parameter int                DATA_W  = 8,
    parameter int                BEATS   = 4,
    parameter int                KEY_W   = 4,
    parameter logic [KEY_W-1:0]  KEY_VAL = 4'hA,
    localparam int               SUM_W   = DATA_W + $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int CNT_W = $clog2(BEATS + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and ready/valid here depend on state only.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        OUT   = 2'd2
`ifdef LOCK_EN
        , ACC_D = 2'd3
`endif
    } state_t;

    state_t             state, state_next;
    logic [SUM_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]   beat_cnt, cnt_next;
    logic               take;
    logic [DATA_W-1:0]  inv_data;
    logic [SUM_W-1:0]   ext_data;
    logic [SUM_W-1:0]   ext_inv;

    assign inv_data  = ~in_data;
    assign ext_data  = {{(SUM_W-DATA_W){1'b0}}, in_data};
    assign ext_inv   = {{(SUM_W-DATA_W){1'b0}}, inv_data};

    assign in_ready  = (state != OUT);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign take      = in_valid && in_ready;

`ifndef LOCK_EN
    logic unused_key;
    assign unused_key = ^key;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            beat_cnt <= cnt_next;
            if (out_valid && out_ready)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = beat_cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    cnt_next = CNT_W'(1);
`ifdef LOCK_EN
                    if (key == KEY_VAL) begin
                        acc_next   = ext_data;
                        state_next = ACC;
                    end else begin
                        acc_next   = ext_inv;
                        state_next = ACC_D;
                    end
`else
                    acc_next   = ext_data;
                    state_next = ACC;
`endif
                end
            end
            ACC: begin
                if (take) begin
                    acc_next = acc + ext_data;
                    cnt_next = beat_cnt + CNT_W'(1);
                    if (beat_cnt == CNT_W'(BEATS - 1))
                        state_next = OUT;
                end
            end
`ifdef LOCK_EN
            // Decoy twin of ACC: same timing, inverted beats.
            ACC_D: begin
                if (take) begin
                    acc_next = acc + ext_inv;
                    cnt_next = beat_cnt + CNT_W'(1);
                    if (beat_cnt == CNT_W'(BEATS - 1))
                        state_next = OUT;
                end
            end
`endif
            OUT: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_keyed_accum_fsm.sv
// Self-checking bench for keyed_accum_fsm: scoreboard of frame sums plus per-scenario checks.
module tb_keyed_accum_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'h0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy;
    logic [7:0] frame_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    logic [9:0] exp_q[$];
    logic [7:0] exp_fc = 8'd0;

    keyed_accum_fsm #(.DATA_W(8), .BEATS(4), .KEY_W(4), .KEY_VAL(4'hA)) dut (
        .clk(clk), .rst(rst), .key(key), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: each output handshake pops one expected sum.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got out_data=%h with empty queue", out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    tests_failed++;
                    $display("FAIL sb_sum: got %h expected %h", out_data, e);
                end
            end
            exp_fc = exp_fc + 8'd1;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [3:0] k);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        key      = k;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL beat_timeout: in_ready never high");
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [9:0] model(input logic [31:0] beats, input logic [3:0] k);
        logic [9:0] s;
        bit decoy;
        s = 10'd0;
`ifdef LOCK_EN
        decoy = (k != 4'hA);
`else
        decoy = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = beats[8*i +: 8];
            if (decoy) b = ~b;
            s = s + {2'b00, b};
        end
        return s;
    endfunction

    task automatic send_frame(input logic [31:0] beats, input logic [3:0] k_first,
                              input logic [3:0] k_rest, input int gap);
        exp_q.push_back(model(beats, k_first));
        for (int i = 0; i < 4; i++) begin
            send_beat(beats[8*i +: 8], (i == 0) ? k_first : k_rest);
            if (i < 3 && gap > 0) idle_cycles(gap);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d sums outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle_cycles(2);
        exp_q.delete();
        exp_fc = 8'd0;
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic check_idle(input string name);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            frame_cnt !== exp_fc || out_data !== 10'h000) begin
            tests_failed++;
            $display("FAIL %s: busy=%b out_valid=%b in_ready=%b frame_cnt=%0d out_data=%h, required 0 0 1 %0d 000",
                     name, busy, out_valid, in_ready, frame_cnt, out_data, exp_fc);
        end
    endtask

    task automatic test_reset();
        #2;
        check_idle("reset_async");
        do_reset();
        check_idle("reset_release");
    endtask

    task automatic test_correct_key();
        send_frame({8'd4, 8'd3, 8'd2, 8'd1}, 4'hA, 4'hA, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 10'h00A || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL correct_key_latency: out_valid=%b out_data=%h in_ready=%b, required 1 00a 0",
                     out_valid, out_data, in_ready);
        end
        wait_drain();
        tests_run++;
        if (frame_cnt !== 8'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL correct_key_count: frame_cnt=%0d out_valid=%b, required 1 0", frame_cnt, out_valid);
        end
    endtask

    task automatic test_wrong_key();
        logic [9:0] req;
`ifdef LOCK_EN
        req = 10'h3F2;
`else
        req = 10'h00A;
`endif
        send_frame({8'd4, 8'd3, 8'd2, 8'd1}, 4'h0, 4'h0, 0);
        tests_run++;
        if (out_data !== req || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrong_key_sum: out_data=%h out_valid=%b, required %h 1", out_data, out_valid, req);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] fc0;
        fc0 = exp_fc;
        out_ready = 1'b0;
        send_frame(32'hFFFF_FFFF, 4'hA, 4'hA, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 10'h3FC || in_ready !== 1'b0 || frame_cnt !== fc0) begin
                tests_failed++;
                $display("FAIL backpressure_hold: out_valid=%b out_data=%h in_ready=%b frame_cnt=%0d, required 1 3fc 0 %0d",
                         out_valid, out_data, in_ready, frame_cnt, fc0);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        tests_run++;
        if (frame_cnt !== fc0 + 8'd1) begin
            tests_failed++;
            $display("FAIL backpressure_count: frame_cnt=%0d, required %0d", frame_cnt, fc0 + 8'd1);
        end
    endtask

    task automatic test_key_change_bubbles();
        send_frame({8'd4, 8'd3, 8'd2, 8'd1}, 4'hA, 4'h3, 2);
        tests_run++;
        if (out_data !== 10'h00A) begin
            tests_failed++;
            $display("FAIL key_change_sum: out_data=%h, required 00a", out_data);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_frame();
        send_beat(8'd7, 4'hA);
        send_beat(8'd9, 4'hA);
        rst = 1'b1;
        #1;
        exp_fc = 8'd0;
        check_idle("reset_mid_frame");
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        check_idle("reset_mid_release");
        send_frame({8'd5, 8'd5, 8'd5, 8'd5}, 4'hA, 4'hA, 0);
        tests_run++;
        if (out_data !== 10'h014) begin
            tests_failed++;
            $display("FAIL reset_next_frame: out_data=%h, required 014", out_data);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int f = 0; f < 256; f++) begin
            logic [31:0] b;
            logic [3:0]  k;
            b = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
            k = ($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom_range(0, 9));
            send_frame(b, k, 4'($urandom_range(0, 15)), 0);
        end
        wait_drain();
        tests_run++;
        if (frame_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_zero: frame_cnt=%0d, required 0", frame_cnt);
        end
        send_frame({8'd1, 8'd1, 8'd1, 8'd1}, 4'hA, 4'hA, 0);
        wait_drain();
        tests_run++;
        if (frame_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL wrap_one: frame_cnt=%0d, required 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_correct_key();
        test_wrong_key();
        test_backpressure();
        test_key_change_bubbles();
        test_reset_mid_frame();
        test_back_to_back_wrap();
        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
